pulse_sched: RTL and testbench
==============================

PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter PW, default 4, pulse width in low-rate periods.
REQ-003 SHALL have parameter R_MAIN_TO_LOW, default 1000, clk_main cycles per low-rate period.
REQ-004 SHALL have parameter GAP, default 16, idle clk_main cycles enforced between pulses (>=1).
REQ-005 SHALL have port clk_main, input, 1, the only clock.
REQ-006 SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req, input, N_REQ, per-requester level request sampled every clk_main edge.
REQ-008 SHALL have port tstamp, output, 1, shared extended pulse, registered.
REQ-009 SHALL have port grant, output, N_REQ, one-hot owner of the current pulse; zero otherwise.
REQ-010 SHALL have port done, output, N_REQ, one-cycle completion strobe to the served requester.
REQ-011 SHALL have port pend, output, N_REQ, latched pending requests.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL define L = PW*R_MAIN_TO_LOW; the counter width SHALL be $clog2(max(L,GAP)+1).
REQ-014 SHALL update pend each cycle as (pend | req) & ~load_mask, where load_mask is the one-hot grant being loaded that cycle; a req bit high in its own load cycle is absorbed, not re-queued.
REQ-015 SHALL implement states IDLE, PULSE, GAP.
REQ-016 In IDLE with pend != 0, SHALL select the winner round-robin: first set bit scanning upward from ptr, wrapping at N_REQ-1 to 0; ptr becomes winner+1 mod N_REQ.
REQ-017 SHALL enter PULSE on the edge after selection; tstamp and grant SHALL be high from that cycle for exactly L cycles.
REQ-018 On the last PULSE cycle the counter SHALL reach L-1; the next state SHALL be GAP (macro defined) or IDLE (macro undefined).
REQ-019 done[winner] SHALL pulse high for exactly the first cycle after tstamp falls; grant SHALL be zero in that cycle.
REQ-020 GAP SHALL last exactly GAP cycles with tstamp=0, then return to IDLE; arbitration SHALL NOT occur during PULSE or GAP.
REQ-021 Requests arriving during PULSE/GAP SHALL be latched in pend and served afterward in round-robin order.
REQ-022 With pend == 0 in IDLE, the block SHALL remain in IDLE with all outputs except pend at zero.

Reset
REQ-023 clr_n low SHALL asynchronously force state=IDLE, counter=0, ptr=0, pend=0, tstamp=0, grant=0, done=0, busy=0.
REQ-024 Reset asserted mid-PULSE SHALL drop tstamp immediately, discard pending requests, and produce no done strobe.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk_main by the integrator; the block adds no synchronizer.

Configuration
REQ-026 Macro PULSE_SCHED_GAP_EN defined SHALL include the GAP state and the GAP parameter's effect.
REQ-027 Without PULSE_SCHED_GAP_EN, PULSE SHALL go directly to IDLE, allowing back-to-back pulses separated by one low cycle (the IDLE arbitration cycle); GAP SHALL be ignored.

Structure
REQ-028 State enum (IDLE, PULSE, GAP) and the counter-width function SHALL reside in shared package pulse_sched_pkg.
REQ-029 The round-robin selector SHALL be sub-module rr_pick (inputs pend, ptr; outputs one-hot win, valid), combinational, reusable elsewhere.

Verification (bench params N_REQ=4, PW=2, R_MAIN_TO_LOW=3 -> L=6, GAP=2)
REQ-030 Single req[2] held 1 cycle from IDLE -> pend=0100 next cycle, tstamp high 6 cycles starting 2 cycles after req, grant=0100, done[2] one cycle after tstamp falls.
REQ-031 req=1111 in one cycle after reset -> grants in order 0001, 0010, 0100, 1000; each tstamp=6 cycles, separated by 2 GAP cycles plus 1 IDLE cycle.
REQ-032 req[1] held continuously while req[3] pulses once during req[1]'s PULSE -> next grant is 1000, then 0010 (no starvation).
REQ-033 clr_n low at PULSE cycle 3 -> tstamp=0 asynchronously, pend=0, no done; after release, idle until a new req.
REQ-034 Without PULSE_SCHED_GAP_EN, req=0011 -> tstamp high 6, low 1, high 6; done[0] coincides with the IDLE cycle.
REQ-035 req[0] asserted exactly in its own load cycle only -> single pulse, pend stays 0000 afterward.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types and sizing helpers for the pulse scheduler.
// The GAP state is only reachable when PULSE_SCHED_GAP_EN is defined.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Counter must hold the larger of the pulse length and the gap length.
  function automatic int cnt_width(input int l, input int gap);
    int m;
    m = (l > gap) ? l : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend scanning upward from ptr,
// wrapping at N-1 back to 0. Produces a one-hot winner and a valid flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pend,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PTR_W-1:0];
      if (!valid && pend[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one extended timestamp pulse among N_REQ requesters.
// Define PULSE_SCHED_GAP_EN to insert GAP idle cycles after every pulse.
//
// state    | meaning
// ST_IDLE  | no pulse; arbitrate among pending requests
// ST_PULSE | tstamp/grant high for L = PW*R_MAIN_TO_LOW cycles
// ST_GAP   | enforced quiet time of GAP cycles (PULSE_SCHED_GAP_EN only)
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int PW            = 4,
  parameter int R_MAIN_TO_LOW = 1000,
  parameter int GAP           = 16
) (
  input  logic             clk_main,
  input  logic             clr_n,
  input  logic [N_REQ-1:0] req,
  output logic             tstamp,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] pend,
  output logic             busy
);

  localparam int L     = PW * R_MAIN_TO_LOW;
  localparam int CNT_W = cnt_width(L, GAP);
  localparam int PTR_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   pend_q, pend_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               tstamp_q, tstamp_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   win;
  logic               valid;
  logic [N_REQ-1:0]   load_mask;
  logic [PTR_W-1:0]   ptr_nxt;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .pend  (pend_q),
    .ptr   (ptr_q),
    .win   (win),
    .valid (valid)
  );

  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) ptr_nxt = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = '0;
    done_d    = '0;
    tstamp_d  = 1'b0;
    load_mask = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (valid) begin
          state_d   = ST_PULSE;
          grant_d   = win;
          tstamp_d  = 1'b1;
          ptr_d     = ptr_nxt;
          load_mask = win;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(L - 1)) begin
          // Completion strobe lands in the first cycle after tstamp falls.
          done_d = grant_q;
          cnt_d  = '0;
`ifdef PULSE_SCHED_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d    = cnt_q + 1'b1;
          grant_d  = grant_q;
          tstamp_d = 1'b1;
        end
      end
`ifdef PULSE_SCHED_GAP_EN
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pend_d = (pend_q | req) & ~load_mask;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_main or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      pend_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      tstamp_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tstamp_q <= tstamp_d;
      busy_q   <= busy_d;
    end
  end

  assign tstamp = tstamp_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign pend   = pend_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched (N_REQ=4, PW=2, R_MAIN_TO_LOW=3 -> L=6, GAP=2).
// Expectations adapt to whether PULSE_SCHED_GAP_EN is defined.
module tb_pulse_sched;

  localparam int N_REQ = 4;
  localparam int L_EXP = 6;
`ifdef PULSE_SCHED_GAP_EN
  localparam int GAP_CYC = 2;
`else
  localparam int GAP_CYC = 0;
`endif

  logic             clk_main = 1'b0;
  logic             clr_n    = 1'b0;
  logic [N_REQ-1:0] req      = '0;
  logic             tstamp;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] pend;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  pulse_sched #(
    .N_REQ         (N_REQ),
    .PW            (2),
    .R_MAIN_TO_LOW (3),
    .GAP           (2)
  ) dut (
    .clk_main (clk_main),
    .clr_n    (clr_n),
    .req      (req),
    .tstamp   (tstamp),
    .grant    (grant),
    .done     (done),
    .pend     (pend),
    .busy     (busy)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    req   = '0;
    @(posedge clk_main);
    #1;
    clr_n = 1'b1;
  endtask

  // Starts in a cycle with tstamp high; ends in the first cycle with tstamp low.
  task automatic measure_pulse(output int w, output logic [N_REQ-1:0] g,
                               output logic [N_REQ-1:0] d);
    int guard;
    w = 0;
    guard = 0;
    g = grant;
    while (tstamp === 1'b1 && guard < 50) begin
      w++;
      guard++;
      step();
    end
    if (guard >= 50) w = -1;
    d = done;
  endtask

  task automatic measure_low(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (tstamp !== 1'b1 && guard < 50) begin
      n++;
      guard++;
      step();
    end
    if (guard >= 50) n = -1;
  endtask

  initial begin
    int w, n;
    logic [N_REQ-1:0] g, d;
    logic seen_ts, seen_done;

    // Reset state
    #2;
    chk("rst_tstamp", 32'(tstamp), 0);
    chk("rst_grant",  32'(grant),  0);
    chk("rst_done",   32'(done),   0);
    chk("rst_pend",   32'(pend),   0);
    chk("rst_busy",   32'(busy),   0);
    do_reset();

    // Single request on bit 2
    req = 4'b0100;
    step();
    req = '0;
    chk("a_pend",     32'(pend),   32'h4);
    chk("a_ts_pre",   32'(tstamp), 0);
    step();
    chk("a_ts_on",    32'(tstamp), 1);
    chk("a_grant",    32'(grant),  32'h4);
    chk("a_pend_clr", 32'(pend),   0);
    chk("a_busy",     32'(busy),   1);
    measure_pulse(w, g, d);
    chk("a_width",    32'(w), 32'(L_EXP));
    chk("a_done",     32'(d), 32'h4);
    chk("a_grant_off", 32'(grant), 0);
    chk("a_busy_end", 32'(busy), (GAP_CYC > 0) ? 1 : 0);
    step();
    chk("a_done_once", 32'(done), 0);
    repeat (10) step();
    chk("a_idle_ts",   32'(tstamp), 0);
    chk("a_idle_busy", 32'(busy),   0);
    chk("a_idle_grant", 32'(grant), 0);

    // All four requesters at once after reset
    do_reset();
    req = 4'b1111;
    step();
    req = '0;
    chk("b_pend", 32'(pend), 32'hf);
    step();
    for (int k = 0; k < 4; k++) begin
      measure_pulse(w, g, d);
      chk("b_width", 32'(w), 32'(L_EXP));
      chk("b_grant", 32'(g), 32'(1 << k));
      chk("b_done",  32'(d), 32'(1 << k));
      if (k < 3) begin
        measure_low(n);
        chk("b_low", 32'(n), 32'(GAP_CYC + 1));
      end
    end
    chk("b_pend_end", 32'(pend), 0);

    // Continuous req[1] must not starve a one-shot req[3]
    do_reset();
    req = 4'b0010;
    step();
    step();
    chk("c_grant1", 32'(grant), 32'h2);
    step();
    step();
    req = 4'b1010;
    step();
    req = 4'b0010;
    measure_pulse(w, g, d);
    chk("c_first", 32'(g), 32'h2);
    measure_low(n);
    measure_pulse(w, g, d);
    chk("c_second", 32'(g), 32'h8);
    measure_low(n);
    measure_pulse(w, g, d);
    chk("c_third", 32'(g), 32'h2);
    req = '0;

    // Reset in the third PULSE cycle
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    step();
    step();
    req = 4'b0100;
    step();
    req = '0;
    chk("d_ts_mid",   32'(tstamp), 1);
    chk("d_pend_mid", 32'(pend),   32'h4);
    #2;
    clr_n = 1'b0;
    #1;
    chk("d_ts_async",   32'(tstamp), 0);
    chk("d_pend_async", 32'(pend),   0);
    chk("d_grant_async", 32'(grant), 0);
    chk("d_busy_async", 32'(busy),   0);
    @(posedge clk_main);
    #1;
    clr_n = 1'b1;
    seen_ts = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen_ts   = seen_ts | tstamp;
      seen_done = seen_done | (|done);
    end
    chk("d_no_ts",   32'(seen_ts),   0);
    chk("d_no_done", 32'(seen_done), 0);

    // Request held through its own load cycle is absorbed
    req = 4'b0001;
    step();
    step();
    req = '0;
    chk("e_ts",   32'(tstamp), 1);
    chk("e_pend", 32'(pend),   0);
    measure_pulse(w, g, d);
    chk("e_width", 32'(w), 32'(L_EXP));
    seen_ts = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_ts = seen_ts | tstamp;
    end
    chk("e_single", 32'(seen_ts), 0);
    chk("e_pend_end", 32'(pend), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
